sram_pipelined: RTL

- Single-port, parametrised SRAM that succeeds the flat register-array memory.
- Valid/ready request channel with byte-masked writes.
- Configurable read latency pipeline, plus a credit-controlled response buffer so the consumer can apply backpressure.
- Hardware zero-initialisation after reset. Sits between cache/LSU-style requesters and the storage array.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_resp_fifo.sv | 71 +++++++
 rtl/sram_pipelined.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and width helpers for the pipelined SRAM.
// Imported by the top and by the response FIFO.
package sram_pkg;

  typedef enum logic {
    INIT,
    RUN
  } fsm_e;

  localparam int DefEleLen = 32;
  localparam int MaskWidth = DefEleLen / 8;

  // Width of an index into n entries, never below 1 bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter able to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return safe_clog2(n + 1);
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Holds read responses until the consumer pops them.
module sram_resp_fifo
  import sram_pkg::*;
#(
  parameter int Width = DefEleLen,
  parameter int Depth = 4,
  parameter int CntW  = cnt_width(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [Width-1:0] o_data,
  output logic [CntW-1:0]  o_count
);

  localparam int PW = safe_clog2(Depth);
  localparam logic [PW-1:0] LastIdx = PW'(Depth - 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CntW'(Depth));
  assign o_valid   = (r_count != '0);
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && o_valid;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= (r_wptr == LastIdx) ? '0 : r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == LastIdx) ? '0 : r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Credits upstream make a dropped push impossible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_push && !w_do_push));
    end
  end

endmodule

// File: rtl/sram_pipelined.sv
// Single-port SRAM with masked writes, fixed read latency and a
// credit-controlled FWFT response buffer; zeroes itself after reset.
module sram_pipelined
  import sram_pkg::*;
#(
  parameter int EleLen      = DefEleLen,
  parameter int EleIdxWidth = 10,
  parameter int NumEle      = 2 ** EleIdxWidth,
  parameter int ReadLatency = 2,
  parameter int RespDepth   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [EleIdxWidth-1:0] req_addr,
  input  logic [EleLen-1:0]      req_wdata,
  input  logic [EleLen/8-1:0]    req_wmask,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [EleLen-1:0]      resp_rdata,
  output logic                   init_done
);

  localparam int MW = EleLen / 8;
  localparam int CW = cnt_width(RespDepth);
  localparam logic [EleIdxWidth-1:0] LastEle =
    EleIdxWidth'(NumEle - 1);

  fsm_e                   r_state;
  fsm_e                   w_state_nxt;
  logic [EleIdxWidth-1:0] r_init_cnt;
  logic                   r_init_done;
  logic [CW-1:0]          r_credits;
  logic [EleLen-1:0]      r_mem [NumEle];

  logic              w_run;
  logic              w_init_last;
  logic              w_in_range;
  logic              w_acc;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_pop;
  logic [EleLen-1:0] w_rd_data;
  logic              w_push;
  logic [EleLen-1:0] w_push_data;
  logic              w_fifo_valid;
  logic [EleLen-1:0] w_fifo_data;
  logic [CW-1:0]     w_fifo_cnt;

  assign w_run       = (r_state == RUN);
  assign w_init_last = (r_init_cnt == LastEle);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      INIT: begin
        if (w_init_last) begin
          w_state_nxt = RUN;
        end
      end
      RUN: w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == INIT) begin
      if (w_init_last) begin
        r_init_done <= 1'b1;
      end else begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  if (NumEle < 2 ** EleIdxWidth) begin : g_range
    assign w_in_range = (32'(req_addr) < 32'(NumEle));
  end else begin : g_full
    assign w_in_range = 1'b1;
  end

  // Read credits never depend on the request payload or valid.
  assign req_ready = !rst && w_run &&
                     (req_write || (r_credits != '0));

  assign w_acc = req_valid && req_ready;

  always_comb begin
    w_wr_acc = 1'b0;
    w_rd_acc = 1'b0;
    unique case (1'b1)
      w_acc &&  req_write: w_wr_acc = 1'b1;
      w_acc && !req_write: w_rd_acc = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_wr_acc && w_in_range) begin
      for (int b = 0; b < MW; b++) begin
        if (req_wmask[b]) begin
          r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign w_rd_data = w_in_range ? r_mem[req_addr] : '0;

  // The acceptance edge is the first latency cycle.
  if (ReadLatency <= 1) begin : g_nopipe
    assign w_push      = w_rd_acc;
    assign w_push_data = w_rd_data;
  end else begin : g_pipe
    localparam int P = ReadLatency - 1;

    logic [P-1:0]      r_pv;
    logic [EleLen-1:0] r_pd [P];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pv <= '0;
      end else begin
        r_pv[0] <= w_rd_acc;
        for (int i = 1; i < P; i++) begin
          r_pv[i] <= r_pv[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      r_pd[0] <= w_rd_data;
      for (int i = 1; i < P; i++) begin
        r_pd[i] <= r_pd[i-1];
      end
    end

    assign w_push      = r_pv[P-1];
    assign w_push_data = r_pd[P-1];
  end

  sram_resp_fifo #(
    .Width (EleLen),
    .Depth (RespDepth),
    .CntW  (CW)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_cnt)
  );

  assign resp_valid = !rst && w_fifo_valid;
  assign resp_rdata = resp_valid ? w_fifo_data : '0;
  assign init_done  = !rst && r_init_done;
  assign w_pop      = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= CW'(RespDepth);
    end else begin
      case ({w_rd_acc, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Free credits plus buffered data can never exceed the buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(r_credits) + int'(w_fifo_cnt) <= RespDepth);
    end
  end

endmodule
